// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load handshake.
// Optional build macro PISO_PARITY_EN adds one even-parity bit after the data bits.
// All outputs are registered. The first bit appears in the cycle after accept.
module piso_tx #(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] parallel_i,
   input  logic         valid_i,
   output logic         ready_o,
   output logic         serial_o,
   output logic         frame_o,
   output logic         done_o
);

   localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t          state_q, state_d;
   logic [N-1:0]    shreg_q, shreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            serial_q, serial_d;
   logic            frame_q, frame_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;
`ifdef PISO_PARITY_EN
   logic            par_q, par_d;
`endif

   // Next-state and registered-output logic. cnt_q is the index of the bit
   // currently on serial_o, so the next bit is staged one cycle ahead.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      serial_d = serial_q;
      frame_d  = frame_q;
      done_d   = 1'b0;
      ready_d  = ready_q;
`ifdef PISO_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_i && ready_q) begin
               state_d  = SHIFT;
               shreg_d  = parallel_i;
               cnt_d    = '0;
               serial_d = MSB_FIRST ? parallel_i[N-1] : parallel_i[0];
               frame_d  = 1'b1;
               ready_d  = 1'b0;
`ifdef PISO_PARITY_EN
               par_d    = ^parallel_i;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
               state_d  = PARITY;
               serial_d = par_q;
               done_d   = 1'b1;
`else
               state_d  = IDLE;
               serial_d = 1'b1;
               frame_d  = 1'b0;
               ready_d  = 1'b1;
`endif
            end else begin
               cnt_d    = cnt_q + CW'(1);
               shreg_d  = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
               serial_d = MSB_FIRST ? shreg_q[N-2] : shreg_q[1];
`ifndef PISO_PARITY_EN
               done_d   = (cnt_q == (LAST - CW'(1)));
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            state_d  = IDLE;
            serial_d = 1'b1;
            frame_d  = 1'b0;
            ready_d  = 1'b1;
         end
`endif
         default: begin
            state_d  = IDLE;
            serial_d = 1'b1;
            frame_d  = 1'b0;
            ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         serial_q <= 1'b1;
         frame_q  <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
`ifdef PISO_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         serial_q <= serial_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
`ifdef PISO_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign ready_o  = ready_q;
   assign serial_o = serial_q;
   assign frame_o  = frame_q;
   assign done_o   = done_q;

endmodule
